// File: rtl/stream_mux_rr_if.sv
// Bundle of the N producer streams, mode/select controls and the single consumer stream
// that surround stream_mux_rr.
interface stream_mux_rr_if #(
    parameter int WIDTH = 2,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    // Valid/ready: a word moves on a cycle where valid and ready are both high.
    // A producer holds data and valid until that happens, and ready never depends on data.
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               mode;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic [SELW-1:0]    out_src;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_src, out_valid
    );

    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_src, out_valid
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-input registered stream multiplexer. It grants one channel either by an explicit
// select or by round-robin, and the winning word goes through a one-entry output register.
module stream_mux_rr #(
    parameter int WIDTH = 2,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic           clk,
    input  logic           rst,
    stream_mux_rr_if.slave s
);
    logic [SELW-1:0]  ptr;
    logic [WIDTH-1:0] data_q;
    logic [SELW-1:0]  src_q;
    logic             valid_q;

    logic             adv;
    logic             gnt;
    logic [SELW-1:0]  gnt_idx;

    assign adv = !valid_q || s.out_ready;

    // Round-robin searches from ptr+1 upward, so after reset (ptr=N-1) channel 0 is checked first.
    always_comb begin
        gnt     = 1'b0;
        gnt_idx = '0;
        if (!s.mode) begin
            for (int i = 0; i < N; i++) begin
                if (s.sel == SELW'(i) && s.in_valid[i]) begin
                    gnt     = 1'b1;
                    gnt_idx = SELW'(i);
                end
            end
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!gnt && s.in_valid[(int'(ptr) + k) % N]) begin
                    gnt     = 1'b1;
                    gnt_idx = SELW'((int'(ptr) + k) % N);
                end
            end
        end
    end

    // Ready is masked while rst is high. Otherwise an empty register would accept during reset.
    assign s.in_ready = (adv && gnt && !rst) ? (N'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
            ptr     <= SELW'(N - 1);
        end else if (adv) begin
            if (gnt) begin
                data_q  <= s.in_data[int'(gnt_idx)*WIDTH +: WIDTH];
                src_q   <= gnt_idx;
                valid_q <= 1'b1;
                ptr     <= gnt_idx;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign s.out_data  = data_q;
    assign s.out_src   = src_q;
    assign s.out_valid = valid_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr with a 4-channel, 8-bit instance and a 3-channel instance.
// The 3-channel instance covers the case where sel is out of range.
module tb_stream_mux_rr;
  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  stream_mux_rr_if #(.WIDTH(8), .N(4), .SELW(2)) b4 ();
  stream_mux_rr_if #(.WIDTH(8), .N(3), .SELW(2)) b3 ();

  stream_mux_rr #(.WIDTH(8), .N(4), .SELW(2)) dut (
    .clk (clk),
    .rst (rst),
    .s   (b4.slave)
  );

  stream_mux_rr #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
    .clk (clk),
    .rst (rst),
    .s   (b3.slave)
  );

  int total = 0;
  int bad = 0;

  // Each entry is {src, data}.
  logic [9:0] exp_q[$];
  logic [7:0] ch[4];
  logic [1:0] m_ptr;
  logic       m_ov;
  logic [9:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [1:0] sl, input logic [3:0] v, input logic r);
    b4.mode      = m;
    b4.sel       = sl;
    b4.in_valid  = v;
    b4.out_ready = r;
    b4.in_data   = {ch[3], ch[2], ch[1], ch[0]};
  endtask

  task automatic model_reset();
    m_ptr  = 2'd3;
    m_ov   = 1'b0;
    m_last = 10'd0;
    exp_q.delete();
  endtask

  // Predict the grant, check in_ready, clock once, then check the output register.
  task automatic step(input string tag);
    logic       g;
    logic [1:0] gi;
    logic       adv;
    logic [3:0] er;
    #1;
    g  = 1'b0;
    gi = 2'd0;
    if (!b4.mode) begin
      if (b4.in_valid[b4.sel]) begin
        g  = 1'b1;
        gi = b4.sel;
      end
    end else begin
      for (int k = 1; k <= 4; k++) begin
        logic [1:0] c;
        c = m_ptr + 2'(k);
        if (!g && b4.in_valid[c]) begin
          g  = 1'b1;
          gi = c;
        end
      end
    end
    adv = !m_ov || b4.out_ready;
    er  = (adv && g) ? (4'b0001 << gi) : 4'b0000;
    chk({tag, ":in_ready"}, 32'(b4.in_ready), 32'(er));
    if (adv) begin
      if (g) begin
        exp_q.push_back({gi, ch[gi]});
        m_ptr = gi;
        m_ov  = 1'b1;
      end else begin
        m_ov = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) m_last = exp_q.pop_front();
    chk({tag, ":out_valid"}, 32'(b4.out_valid), 32'(m_ov));
    chk({tag, ":out_word"}, 32'({b4.out_src, b4.out_data}), 32'(m_last));
  endtask

  initial begin
    ch[0] = 8'h10;
    ch[1] = 8'h11;
    ch[2] = 8'hA5;
    ch[3] = 8'h13;

    // Reset with random inputs applied
    #1 rst = 1'b1;
    drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 1)));
    b3.mode      = 1'($urandom_range(0, 1));
    b3.sel       = 2'($urandom_range(0, 3));
    b3.in_valid  = 3'($urandom_range(0, 7));
    b3.out_ready = 1'($urandom_range(0, 1));
    b3.in_data   = 24'h332211;
    #2;
    chk("rst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("rst_out_data", 32'(b4.out_data), 32'd0);
    chk("rst_out_src", 32'(b4.out_src), 32'd0);
    chk("rst_in_ready", 32'(b4.in_ready), 32'd0);
    chk("rst_in_ready3", 32'(b3.in_ready), 32'd0);
    @(posedge clk);
    #1;
    b3.in_valid = 3'b000;
    rst = 1'b0;
    model_reset();

    // Explicit select of channel 2
    drive(1'b0, 2'd2, 4'b0100, 1'b1);
    step("sel2");
    chk("sel2_data", 32'(b4.out_data), 32'h A5);
    chk("sel2_src", 32'(b4.out_src), 32'd2);

    // Backpressure for three cycles, then release
    drive(1'b0, 2'd1, 4'b0010, 1'b0);
    repeat (3) step("bp");
    chk("bp_hold_data", 32'(b4.out_data), 32'hA5);
    drive(1'b0, 2'd1, 4'b0010, 1'b1);
    step("bp_release");
    chk("bp_rel_data", 32'(b4.out_data), 32'h11);
    chk("bp_rel_src", 32'(b4.out_src), 32'd1);

    // Reset pulsed while the output register holds a word
    drive(1'b1, 2'd0, 4'b1111, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(b4.out_valid), 32'd0);
    chk("midrst_out_data", 32'(b4.out_data), 32'd0);
    chk("midrst_in_ready", 32'(b4.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Round-robin fairness, all channels valid
    drive(1'b1, 2'd0, 4'b1111, 1'b1);
    for (int k = 0; k < 8; k++) begin
      step("rr");
      chk("rr_seq", 32'(b4.out_src), 32'(k % 4));
    end

    // Sparse wrap: grant channel 2 first, then only channels 0 and 3 are valid
    drive(1'b1, 2'd0, 4'b0100, 1'b1);
    step("wrap_pre");
    drive(1'b1, 2'd0, 4'b1001, 1'b1);
    step("wrap1");
    chk("wrap1_src", 32'(b4.out_src), 32'd3);
    step("wrap2");
    chk("wrap2_src", 32'(b4.out_src), 32'd0);
    step("wrap3");
    chk("wrap3_src", 32'(b4.out_src), 32'd3);

    // No valid input: the output register empties and its data holds
    drive(1'b1, 2'd0, 4'b0000, 1'b1);
    step("idle");
    chk("idle_hold_data", 32'(b4.out_data), 32'h13);

    // Switch mode without resetting ptr, under random backpressure
    for (int k = 0; k < 6; k++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));
      step("rand");
    end

    // N=3 instance: a select of 3 never grants
    b3.mode      = 1'b0;
    b3.sel       = 2'd1;
    b3.in_valid  = 3'b111;
    b3.out_ready = 1'b1;
    #1;
    chk("n3_sel1_ready", 32'(b3.in_ready), 32'b010);
    @(posedge clk);
    #1;
    chk("n3_sel1_valid", 32'(b3.out_valid), 32'd1);
    chk("n3_sel1_data", 32'(b3.out_data), 32'h22);
    b3.sel = 2'd3;
    #1;
    chk("n3_sel3_ready", 32'(b3.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("n3_sel3_valid", 32'(b3.out_valid), 32'd0);
    chk("n3_sel3_hold", 32'(b3.out_data), 32'h22);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
Parametrised N-input, WIDTH-bit registered multiplexer with valid/ready handshakes on every input and on the output.
Generalises the 2-bit 2:1 dataflow mux to:
- configurable channel count and width;
- two select modes: explicit select or round-robin arbitration;
- a one-entry output register carrying data and source index.
Sits between multiple producers and a single consumer in the datapath.

Parameters:
WIDTH, 2, data bits per channel (>=1)
N, 4, number of input channels (>=2)
SELW, 2, select/index width; must equal ceil(log2(N))

Ports:
clk        input   1          rising-edge clock
rst        input   1          asynchronous reset, active-high
in_data    input   N*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
in_valid   input   N          per-channel valid
in_ready   output  N          per-channel ready (combinational)
mode       input   1          0 = explicit select, 1 = round-robin
sel        input   SELW       channel index used when mode=0
out_data   output  WIDTH      registered output data
out_src    output  SELW       registered index of the channel that produced out_data
out_valid  output  1          output holds valid data
out_ready  input   1          consumer accepts out_data

Behaviour:
- One clock. Reset is asynchronous and active-high (rst); clock is clk.
- Reset values: out_valid=0, out_data=0, out_src=0, round-robin pointer ptr=N-1. in_ready is 0 during reset.
- Advance condition: adv = !out_valid | out_ready.
  - Output register loads only when adv=1.
  - Otherwise out_data, out_src and out_valid hold stable (backpressure).
- Grant, combinational:
  - mode=0: grant to channel sel if sel<N and in_valid[sel]=1; otherwise no grant. sel>=N never grants and never raises any in_ready.
  - mode=1: grant to the first i with in_valid[i]=1, searching (ptr+1), (ptr+2), ... mod N. No grant if no valid input.
- in_ready[i] = adv & granted(i). At most one bit of in_ready is set per cycle.
- Transfer on channel i occurs when in_valid[i] & in_ready[i].
- Clock edge with adv=1 and a grant to channel g:
  - out_data <= channel g data;
  - out_src <= g;
  - out_valid <= 1;
  - ptr <= g (updated in both modes).
- Clock edge with adv=1 and no grant: out_valid <= 0; out_data and out_src hold.
- Latency: input transfer to out_valid is 1 cycle.
- Throughput: one word per cycle while out_ready=1.
- Output accept and new load in the same cycle is allowed. The register is replaced with no bubble.
- mode and sel are sampled combinationally every cycle. Switching mode takes effect on the next grant decision; ptr is not reset.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, the grant order is 0,1,...,N-1,0,... Every channel is served within N transfers.
- Wrap-around: after a grant to channel N-1, the search starts at channel 0.
- Producers must hold in_data/in_valid until transfer. The block does not check this.
- Reset asserted mid-operation: the output register clears immediately (asynchronous) and any in-flight word is dropped. After release, the first round-robin grant searches from channel 0.

Test Plan:
- Reset: rst=1 with random inputs -> out_valid=0, out_data=0, out_src=0, in_ready=0 immediately. After release, first mode=1 grant with all valid goes to channel 0.
- Explicit select: N=4, WIDTH=8, mode=0, sel=2, ch2 data=0xA5 valid, out_ready=1 -> in_ready=4'b0100. Next cycle out_data=0xA5, out_src=2, out_valid=1.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles with ch1 valid -> in_ready=0; out_data/out_src unchanged. Raise out_ready -> ch1 word loaded next cycle.
- Round-robin fairness: mode=1, all 4 valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3.
- Sparse wrap: mode=1, ptr=2, only ch0 and ch3 valid -> ch3 granted, then ch0, then ch3.
- Edge cases:
  - N=3, mode=0, sel=3 -> no in_ready, out_valid drops to 0.
  - rst pulsed while out_valid=1 -> out_valid=0 within the same cycle.
